// File: rtl/axi_stream_splitter_3.sv
// axi_stream_splitter_3: routes one combined stream to three channel streams by dest code.
// Each channel has a 2-entry FIFO and a tlast generator that fires every TLAST_PERIOD pushes.
// The optional unmatched-beat counter (dropped_beats_o) is built only when the macro
// AXI_SPLITTER_DROP_COUNT_EN is defined.
module axi_stream_splitter_3 #(
  parameter int unsigned COMBINED_DATA_WIDTH = 32,
  parameter int unsigned CHANNEL_DATA_WIDTH  = 16,
  parameter logic [7:0]  DEST_1              = 8'd0,
  parameter logic [7:0]  DEST_2              = 8'd1,
  parameter logic [7:0]  DEST_3              = 8'd2,
  parameter int unsigned TLAST_PERIOD        = 1024,
  parameter string       MSB_DEST_SUPPORT    = "TRUE"
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [COMBINED_DATA_WIDTH-1:0] stream_in_data_i,
  input  logic [7:0]                     stream_in_dest_i,
  input  logic [7:0]                     stream_in_user_i,
  input  logic                           stream_in_valid_i,
  input  logic                           stream_in_tlast_i,
  output logic                           stream_in_ready_o,
  output logic [CHANNEL_DATA_WIDTH-1:0]  stream_out_1_data_o,
  output logic [7:0]                     stream_out_1_dest_o,
  output logic [7:0]                     stream_out_1_user_o,
  output logic                           stream_out_1_valid_o,
  output logic                           stream_out_1_tlast_o,
  input  logic                           stream_out_1_ready_i,
  output logic [CHANNEL_DATA_WIDTH-1:0]  stream_out_2_data_o,
  output logic [7:0]                     stream_out_2_dest_o,
  output logic [7:0]                     stream_out_2_user_o,
  output logic                           stream_out_2_valid_o,
  output logic                           stream_out_2_tlast_o,
  input  logic                           stream_out_2_ready_i,
  output logic [CHANNEL_DATA_WIDTH-1:0]  stream_out_3_data_o,
  output logic [7:0]                     stream_out_3_dest_o,
  output logic [7:0]                     stream_out_3_user_o,
  output logic                           stream_out_3_valid_o,
  output logic                           stream_out_3_tlast_o,
  input  logic                           stream_out_3_ready_i
`ifdef AXI_SPLITTER_DROP_COUNT_EN
  ,
  output logic [15:0]                    dropped_beats_o
`endif
);

  // FIFO entry layout: {data, dest, user, tlast}
  localparam int unsigned EW      = CHANNEL_DATA_WIDTH + 17;
  localparam bit          MsbDest = (MSB_DEST_SUPPORT == "TRUE");

  logic [7:0]    sel_dest;
  logic [2:0]    hit, full, push, pop, out_valid, out_ready;
  logic          in_ready, accept;
  logic [EW-1:0] head [3];

  // stream_in.tlast and the discarded upper data bits are intentionally ignored.
  logic unused_in;
  assign unused_in = ^{stream_in_tlast_i, stream_in_dest_i, stream_in_data_i};

  assign sel_dest  = MsbDest ? stream_in_data_i[COMBINED_DATA_WIDTH-1 -: 8] : stream_in_dest_i;
  assign out_ready = {stream_out_3_ready_i, stream_out_2_ready_i, stream_out_1_ready_i};

  // Priority decode of the selected dest: output 1 wins over 2, 2 over 3.
  always_comb begin
    hit = '0;
    if (sel_dest == DEST_1)      hit[0] = 1'b1;
    else if (sel_dest == DEST_2) hit[1] = 1'b1;
    else if (sel_dest == DEST_3) hit[2] = 1'b1;
  end

  // Ready depends only on the routed FIFO's fullness, never on valid; held low in reset.
  always_comb begin
    in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (hit[i]) in_ready = ~full[i];
    end
    if (!reset) in_ready = 1'b0;
  end

  assign stream_in_ready_o = in_ready;
  assign accept            = stream_in_valid_i & in_ready;
  assign push              = hit & {3{accept}};
  assign pop               = out_valid & out_ready;

  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic [EW-1:0] mem_q [2];
    logic [EW-1:0] mem_d [2];
    logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [15:0]   tcnt_q, tcnt_d;
    logic          tlast_gen;

    assign tlast_gen    = (tcnt_q == 16'(TLAST_PERIOD - 1));
    assign full[g]      = (cnt_q == 2'd2);
    assign out_valid[g] = (cnt_q != 2'd0);
    assign head[g]      = mem_q[rd_ptr_q];

    // FIFO and tlast counter next state; a full FIFO never sees a push since ready is low.
    always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      tcnt_d   = tcnt_q;
      if (push[g]) begin
        mem_d[wr_ptr_q] = {stream_in_data_i[CHANNEL_DATA_WIDTH-1:0], sel_dest,
                           stream_in_user_i, tlast_gen};
        wr_ptr_d        = ~wr_ptr_q;
        tcnt_d          = tlast_gen ? 16'd0 : tcnt_q + 16'd1;
      end
      if (pop[g]) rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + {1'b0, push[g]} - {1'b0, pop[g]};
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
      if (!reset) begin
        mem_q    <= '{default: '0};
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
        cnt_q    <= 2'd0;
        tcnt_q   <= 16'd0;
      end else begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        tcnt_q   <= tcnt_d;
      end
    end
  end

  assign stream_out_1_data_o  = head[0][EW-1 -: CHANNEL_DATA_WIDTH];
  assign stream_out_1_dest_o  = head[0][16:9];
  assign stream_out_1_user_o  = head[0][8:1];
  assign stream_out_1_tlast_o = head[0][0] & out_valid[0];
  assign stream_out_1_valid_o = out_valid[0];
  assign stream_out_2_data_o  = head[1][EW-1 -: CHANNEL_DATA_WIDTH];
  assign stream_out_2_dest_o  = head[1][16:9];
  assign stream_out_2_user_o  = head[1][8:1];
  assign stream_out_2_tlast_o = head[1][0] & out_valid[1];
  assign stream_out_2_valid_o = out_valid[1];
  assign stream_out_3_data_o  = head[2][EW-1 -: CHANNEL_DATA_WIDTH];
  assign stream_out_3_dest_o  = head[2][16:9];
  assign stream_out_3_user_o  = head[2][8:1];
  assign stream_out_3_tlast_o = head[2][0] & out_valid[2];
  assign stream_out_3_valid_o = out_valid[2];

`ifdef AXI_SPLITTER_DROP_COUNT_EN
  logic [15:0] dropped_q, dropped_d;

  // Saturating count of accepted beats whose dest matched no output.
  always_comb begin
    dropped_d = dropped_q;
    if (accept && (hit == 3'b000) && (dropped_q != 16'hFFFF)) dropped_d = dropped_q + 16'd1;
  end

  // Drop counter register, cleared only by reset.
  always_ff @(posedge clock) begin
    if (!reset) dropped_q <= 16'd0;
    else        dropped_q <= dropped_d;
  end

  assign dropped_beats_o = dropped_q;
`endif

endmodule

// File: tb/tb_axi_stream_splitter_3.sv
// Testbench for axi_stream_splitter_3: directed scenarios plus random traffic, checked by a
// queue-based reference model and a negedge monitor. Uses TLAST_PERIOD = 4.
module tb_axi_stream_splitter_3;

  localparam int TP = 4;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  dest;
    logic [7:0]  user;
    logic        last;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = '0;
  logic [7:0]  in_dest = '0;
  logic [7:0]  in_user = '0;
  logic        in_valid = 1'b0;
  logic        in_tlast = 1'b0;
  logic        in_ready;
  logic [2:0]  out_ready = 3'b111;
  logic [15:0] od [3];
  logic [7:0]  odest [3];
  logic [7:0]  ouser [3];
  logic [2:0]  ov, ot;
  logic [15:0] dropped;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q [3][$];
  int    tcount [3];
  int    drops = 0;
  bit    rand_rdy = 1'b0;

  always #5 clock = ~clock;

  axi_stream_splitter_3 #(
    .COMBINED_DATA_WIDTH(32),
    .CHANNEL_DATA_WIDTH (16),
    .DEST_1             (8'd0),
    .DEST_2             (8'd1),
    .DEST_3             (8'd2),
    .TLAST_PERIOD       (TP),
    .MSB_DEST_SUPPORT   ("TRUE")
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .stream_in_data_i    (in_data),
    .stream_in_dest_i    (in_dest),
    .stream_in_user_i    (in_user),
    .stream_in_valid_i   (in_valid),
    .stream_in_tlast_i   (in_tlast),
    .stream_in_ready_o   (in_ready),
    .stream_out_1_data_o (od[0]),
    .stream_out_1_dest_o (odest[0]),
    .stream_out_1_user_o (ouser[0]),
    .stream_out_1_valid_o(ov[0]),
    .stream_out_1_tlast_o(ot[0]),
    .stream_out_1_ready_i(out_ready[0]),
    .stream_out_2_data_o (od[1]),
    .stream_out_2_dest_o (odest[1]),
    .stream_out_2_user_o (ouser[1]),
    .stream_out_2_valid_o(ov[1]),
    .stream_out_2_tlast_o(ot[1]),
    .stream_out_2_ready_i(out_ready[1]),
    .stream_out_3_data_o (od[2]),
    .stream_out_3_dest_o (odest[2]),
    .stream_out_3_user_o (ouser[2]),
    .stream_out_3_valid_o(ov[2]),
    .stream_out_3_tlast_o(ot[2]),
    .stream_out_3_ready_i(out_ready[2])
`ifdef AXI_SPLITTER_DROP_COUNT_EN
    ,
    .dropped_beats_o     (dropped)
`endif
  );

`ifndef AXI_SPLITTER_DROP_COUNT_EN
  assign dropped = '0;
`endif

  // Destination code -> output index, -1 when nothing matches.
  function automatic int route(input logic [7:0] d);
    if (d == 8'd0) return 0;
    if (d == 8'd1) return 1;
    if (d == 8'd2) return 2;
    return -1;
  endfunction

  // Monitor + reference model: everything is decided on the negedge before the next posedge.
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_reset: got %b want 0", in_ready);
      end
      for (int c = 0; c < 3; c++) begin
        exp_q[c].delete();
        tcount[c] = 0;
      end
      drops = 0;
    end else begin
      int    r;
      bit    exp_rdy;
      beat_t b;
      r       = route(in_data[31:24]);
      exp_rdy = (r < 0) ? 1'b1 : (exp_q[r].size() < 2);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL in_ready: got %b want %b (data %h)", in_ready, exp_rdy, in_data);
      end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (ov[c] !== (exp_q[c].size() > 0)) begin
          errors++;
          $display("FAIL out%0d_valid: got %b want %b", c + 1, ov[c], exp_q[c].size() > 0);
        end
        if (exp_q[c].size() > 0 && out_ready[c]) begin
          b = exp_q[c].pop_front();
          checks++;
          if ({od[c], odest[c], ouser[c], ot[c]} !== b) begin
            errors++;
            $display("FAIL out%0d_beat: got d=%h dest=%h user=%h last=%b want d=%h dest=%h user=%h last=%b",
                     c + 1, od[c], odest[c], ouser[c], ot[c], b.d, b.dest, b.user, b.last);
          end
        end
      end
      if (in_valid && exp_rdy) begin
        if (r < 0) begin
          if (drops < 65535) drops++;
        end else begin
          b.d    = in_data[15:0];
          b.dest = in_data[31:24];
          b.user = in_user;
          b.last = (tcount[r] == TP - 1);
          tcount[r] = (tcount[r] + 1) % TP;
          exp_q[r].push_back(b);
        end
      end
`ifdef AXI_SPLITTER_DROP_COUNT_EN
      checks++;
      if (dropped !== 16'(drops)) begin
        errors++;
        $display("FAIL dropped_beats: got %0d want %0d", dropped, drops);
      end
`endif
    end
  end

  // Random consumer backpressure during the random phase.
  always @(posedge clock) begin
    #1;
    if (rand_rdy) out_ready = 3'($urandom);
  end

  // Present one beat (called at posedge+1) and hold it until accepted, with a bounded wait.
  task automatic send(input logic [31:0] d, input logic [7:0] u);
    int n;
    n        = 0;
    in_data  = d;
    in_user  = u;
    in_dest  = 8'($urandom);
    in_tlast = 1'($urandom);
    in_valid = 1'b1;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: beat %h never accepted", d);
        break;
      end
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    logic [31:0] rnd;
    logic [7:0]  dst;
    int          t0;
    int          n;

    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_val("reset_valid", {29'd0, ov}, 32'd0);
    check_val("reset_tlast", {29'd0, ot}, 32'd0);
    check_val("reset_data1", {16'd0, od[0]}, 32'd0);
    check_val("reset_data3", {16'd0, od[2]}, 32'd0);
    @(posedge clock);
    #1;

    // Routing examples.
    send(32'h01FF_8001, 8'h11);
    send(32'h0000_1234, 8'h22);
    send(32'h02FF_F00D, 8'h33);
    repeat (3) @(posedge clock);
    #1;

    // Backpressure on out_1 with a dest-1 beat waiting behind the stalled beats.
    out_ready = 3'b110;
    fork
      begin
        for (int i = 0; i < 4; i++) send(32'h0000_A000 + i, 8'(i));
        send(32'h0100_BEEF, 8'h44);
      end
      begin
        repeat (6) @(posedge clock);
        @(negedge clock);
        check_val("bp_ready_low", {31'd0, in_ready}, 32'd0);
        check_val("bp_out2_idle", {31'd0, ov[1]}, 32'd0);
        @(posedge clock);
        #1 out_ready[0] = 1'b1;
      end
    join
    repeat (4) @(posedge clock);
    #1;

    // tlast generation: 9 beats to dest 2.
    for (int i = 0; i < 9; i++) send(32'h0200_0000 + i, 8'h55);
    repeat (3) @(posedge clock);
    #1;

    // Unmatched dest.
    for (int i = 0; i < 3; i++) send(32'h7E00_0000 + i, 8'h66);
    @(negedge clock);
`ifdef AXI_SPLITTER_DROP_COUNT_EN
    check_val("dropped_3", {16'd0, dropped}, 32'd3);
`endif
    check_val("drop_no_valid", {29'd0, ov}, 32'd0);
    @(posedge clock);
    #1;

    // Reset with two beats buffered in out_2, then the tlast count restarts.
    out_ready = 3'b101;
    send(32'h0100_0001, 8'h01);
    send(32'h0100_0002, 8'h02);
    reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_val("rst_out2_valid", {31'd0, ov[1]}, 32'd0);
    @(posedge clock);
    #1 out_ready = 3'b111;
    for (int i = 0; i < 5; i++) send(32'h0100_0100 + i, 8'h77);
    repeat (3) @(posedge clock);
    #1;

    // Sustained push/pop on out_1: one beat per clock.
    t0 = int'($time);
    for (int i = 0; i < 20; i++) send(32'h0000_C000 + i, 8'h88);
    check_val("throughput_cycles", 32'((int'($time) - t0) / 10), 32'd20);

    // Random traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: dst = 8'd0;
        3, 4:    dst = 8'd1;
        5, 6:    dst = 8'd2;
        7:       dst = 8'h7E;
        default: dst = 8'($urandom);
      endcase
      rnd[31:24] = dst;
      send(rnd, 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clock);
    #1 out_ready = 3'b111;

    // Drain and confirm nothing is left outstanding.
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 50) begin
      @(posedge clock);
      n++;
    end
    check_val("drain_empty", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
    repeat (2) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
